flash_rom_cache: RTL and testbench

Read cache and sequential prefetcher between the chipset ROM read port and the dual-IO SPI flash reader. It turns single-cycle chipset read requests into flash transactions, keeps recently fetched 16-bit words in a small direct-mapped cache, and fetches the next word while the chipset is idle. Kickstart fetch is mostly sequential, so prefetch hides most of the flash's roughly 300 ns random-access latency.

---
 rtl/flash_rom_cache_if.sv | 10 +
 rtl/flash_rom_cache.sv | 119 +++++++++++
 tb/tb_flash_rom_cache.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/flash_rom_cache_if.sv
// flash_rom_cache_if: chipset-side ROM read port of the flash ROM cache.
interface flash_rom_cache_if;
  logic        req;
  logic [21:0] req_addr;
  logic        flush;
  logic        ack;
  logic [15:0] rdata;
  modport master (output req, req_addr, flush, input ack, rdata);
  modport slave (input req, req_addr, flush, output ack, rdata);
endinterface

// File: rtl/flash_rom_cache.sv
// flash_rom_cache: direct-mapped word cache with next-word prefetch between the chipset ROM port and the SPI flash reader.
module flash_rom_cache #(
  parameter int LINES    = 16,
  parameter bit PREFETCH = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  flash_rom_cache_if.slave  bus,
  input  logic              i_flash_ready,
  input  logic              i_flash_busy,
  input  logic [15:0]       i_flash_dout,
  output logic [21:0]       o_flash_address,
  output logic              o_flash_cs
);
  localparam int IW = $clog2(LINES);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  typedef enum logic {F_DEMAND, F_PREFETCH} ftype_t;
  state_t            r_state, w_next;
  ftype_t            r_type;
  logic              r_launch;
  logic [21:0]       r_fetch_addr;
  logic              r_pend;
  logic [21:0]       r_pend_addr;
  logic              r_cand_v;
  logic [21:0]       r_cand_addr;
  logic              r_ack;
  logic [15:0]       r_rdata;
  logic [LINES-1:0]  r_valid;
  logic [21-IW:0]    r_tag [LINES];
  logic [15:0]       r_data [LINES];
  logic              w_req_v, w_hit, w_cand_hit, w_done, w_serve, w_go_demand, w_go_pf;
  logic [21:0]       w_req_addr;
  logic [IW-1:0]     w_idx, w_cidx, w_fidx;
  // A request held back by a busy flash or an unready reader takes the place of the live strobe
  assign w_req_v     = r_pend | bus.req;
  assign w_req_addr  = r_pend ? r_pend_addr : bus.req_addr;
  assign w_idx       = w_req_addr[IW-1:0];
  assign w_cidx      = r_cand_addr[IW-1:0];
  assign w_fidx      = r_fetch_addr[IW-1:0];
  assign w_hit       = r_valid[w_idx] & ~bus.flush & (r_tag[w_idx] == w_req_addr[21:IW]);
  assign w_cand_hit  = r_valid[w_cidx] & (r_tag[w_cidx] == r_cand_addr[21:IW]);
  assign w_done      = (r_state == WAIT_DONE) & ~i_flash_busy;
  assign w_serve     = (r_type == F_DEMAND) | (w_req_v & (w_req_addr == r_fetch_addr));
  assign o_flash_cs      = (r_state == LAUNCH);
  assign o_flash_address = r_fetch_addr;
  assign bus.ack         = r_ack;
  assign bus.rdata       = r_rdata;
  always_comb begin
    w_next      = r_state;
    w_go_demand = 1'b0;
    w_go_pf     = 1'b0;
    case (r_state)
      IDLE: begin
        w_go_demand = w_req_v & ~w_hit & i_flash_ready;
        w_go_pf     = ~w_req_v & r_cand_v & PREFETCH & ~w_cand_hit & i_flash_ready & ~bus.flush;
        w_next      = (w_go_demand | w_go_pf) ? LAUNCH : IDLE;
      end
      LAUNCH:    w_next = r_launch ? WAIT_BUSY : LAUNCH;
      WAIT_BUSY: w_next = i_flash_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: w_next = i_flash_busy ? WAIT_DONE : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_type       <= F_DEMAND;
      r_launch     <= 1'b0;
      r_fetch_addr <= '0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_cand_v     <= 1'b0;
      r_cand_addr  <= '0;
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_valid      <= '0;
    end else begin
      r_state  <= w_next;
      r_launch <= (r_state == LAUNCH) & ~r_launch;
      r_ack    <= 1'b0;
      if (bus.flush) begin
        r_valid  <= '0;
        r_cand_v <= 1'b0;
      end
      if (r_state == IDLE) begin
        if (w_req_v) begin
          r_pend      <= ~w_hit & ~w_go_demand;
          r_pend_addr <= w_req_addr;
          r_ack       <= w_hit;
          if (w_hit) r_rdata <= r_data[w_idx];
        end else if (w_go_pf | w_cand_hit | ~PREFETCH) r_cand_v <= 1'b0;
        if (w_go_demand | w_go_pf) begin
          r_fetch_addr <= w_go_demand ? w_req_addr : r_cand_addr;
          r_type       <= w_go_demand ? F_DEMAND : F_PREFETCH;
        end
      end else if (bus.req & ~r_pend) begin
        r_pend      <= 1'b1;
        r_pend_addr <= bus.req_addr;
      end
      // The completing line write is ordered after flush so it survives a same-cycle flush
      if (w_done) begin
        r_valid[w_fidx] <= 1'b1;
        if (w_serve) begin
          r_ack       <= 1'b1;
          r_rdata     <= i_flash_dout;
          r_pend      <= 1'b0;
          r_cand_v    <= 1'b1;
          r_cand_addr <= r_fetch_addr + 22'd1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_done) begin
      r_tag[w_fidx]  <= r_fetch_addr[21:IW];
      r_data[w_fidx] <= i_flash_dout;
    end
  end
endmodule

// File: tb/tb_flash_rom_cache.sv
// tb_flash_rom_cache: flash reader model, directed table, corner sequences and a randomized run against a line-level cache model.
module tb_flash_rom_cache;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flash_ready = 1'b0;
  logic flash_busy;
  logic [15:0] flash_dout;
  logic [21:0] flash_address;
  logic flash_cs;
  flash_rom_cache_if bus();
  flash_rom_cache #(.LINES(16), .PREFETCH(1'b1)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .i_flash_ready(flash_ready), .i_flash_busy(flash_busy), .i_flash_dout(flash_dout),
    .o_flash_address(flash_address), .o_flash_cs(flash_cs));
  always #5 clk = ~clk;
  int passed = 0, total = 0;
  int cyc = 0, fall_cyc = 0, viol = 0, bad_width = 0, cs_run = 0, ack_count = 0;
  function automatic logic [15:0] fdata(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], 10'h000} ^ 16'h5A3C;
  endfunction
  logic fl_act, fl_done;
  int fl_wait, fl_len;
  logic [21:0] fl_addr;
  logic [21:0] fl_log[$];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fl_act <= 1'b0; fl_done <= 1'b0; flash_busy <= 1'b0; flash_dout <= '0; fl_wait <= 0; fl_len <= 0;
    end else begin
      fl_done <= 1'b0;
      if (flash_cs && !fl_act) begin
        fl_act <= 1'b1; fl_addr <= flash_address; fl_wait <= 2; fl_len <= $urandom_range(3, 9);
        flash_dout <= 16'hDEAD;
        fl_log.push_back(flash_address);
      end else if (fl_act && fl_wait > 0) begin
        fl_wait <= fl_wait - 1;
        if (fl_wait == 1) flash_busy <= 1'b1;
      end else if (fl_act && fl_len > 0) fl_len <= fl_len - 1;
      else if (fl_act) begin
        flash_busy <= 1'b0; flash_dout <= fdata(fl_addr); fl_act <= 1'b0; fl_done <= 1'b1; fall_cyc <= cyc + 1;
      end
    end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flash_cs && flash_busy) viol <= viol + 1;
    if (flash_cs) cs_run <= cs_run + 1;
    else begin
      if (cs_run != 0 && cs_run != 2) bad_width <= bad_width + 1;
      cs_run <= 0;
    end
    if (bus.ack) ack_count <= ack_count + 1;
  end
  logic        mv [16];
  logic [17:0] mt [16];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) for (int i = 0; i < 16; i++) mv[i] <= 1'b0;
    else begin
      if (bus.flush) for (int i = 0; i < 16; i++) mv[i] <= 1'b0;
      if (fl_done) begin
        mv[fl_addr[3:0]] <= 1'b1;
        mt[fl_addr[3:0]] <= fl_addr[21:4];
      end
    end
  end
  function automatic longint logged(input int i);
    return (i < fl_log.size()) ? longint'(fl_log[i]) : -1;
  endfunction
  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_ack(output int lat, output logic [15:0] d);
    lat = 1;
    while (!bus.ack && lat < 300) begin tick(); lat++; end
    check("ack_timeout", lat < 300, 1);
    d = bus.rdata;
  endtask
  task automatic do_req(input logic [21:0] a, input logic fl, output int lat, output logic [15:0] d);
    bus.req = 1'b1; bus.req_addr = a; bus.flush = fl;
    tick();
    bus.req = 1'b0; bus.flush = 1'b0;
    wait_ack(lat, d);
  endtask
  task automatic wait_quiet();
    int q = 0, n = 0;
    while (q < 4 && n < 500) begin
      tick(); n++;
      q = (!fl_act && !fl_done && !flash_cs && !flash_busy) ? q + 1 : 0;
    end
    check("quiet_timeout", n < 500, 1);
  endtask
  task automatic wait_busy();
    int n = 0;
    while (!flash_busy && n < 100) begin tick(); n++; end
    check("busy_timeout", n < 100, 1);
  endtask
  typedef struct packed { logic [21:0] addr; logic flush; logic hit; } vec_t;
  vec_t tbl [12];
  initial begin
    int n, ac, lat, nbad, nreq;
    logic [15:0] d;
    logic [21:0] a, prev;
    logic fl, quiet, ph;
    int r;
    tbl[0]  = '{22'h000010, 1'b0, 1'b0};
    tbl[1]  = '{22'h000020, 1'b0, 1'b0};
    tbl[2]  = '{22'h000010, 1'b0, 1'b0};
    tbl[3]  = '{22'h000011, 1'b0, 1'b1};
    tbl[4]  = '{22'h000012, 1'b0, 1'b0};
    tbl[5]  = '{22'h000013, 1'b0, 1'b1};
    tbl[6]  = '{22'h000010, 1'b1, 1'b0};
    tbl[7]  = '{22'h3FFFFF, 1'b0, 1'b0};
    tbl[8]  = '{22'h000000, 1'b0, 1'b1};
    tbl[9]  = '{22'h3FFFFF, 1'b0, 1'b1};
    tbl[10] = '{22'h3FFFFF, 1'b1, 1'b0};
    tbl[11] = '{22'h000000, 1'b0, 1'b1};
    bus.req = 1'b0; bus.req_addr = '0; bus.flush = 1'b0;
    tick(3);
    check("rst_ack", bus.ack, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_cs", flash_cs, 0);
    check("rst_addr", flash_address, 0);
    resetn = 1'b1;
    tick(2);
    // demand miss held while the flash reader is still initialising
    n = fl_log.size();
    bus.req = 1'b1; bus.req_addr = 22'h000100;
    tick();
    bus.req = 1'b0;
    nbad = 0;
    repeat (10) begin if (flash_cs || bus.ack) nbad++; tick(); end
    check("notready_quiet", nbad, 0);
    flash_ready = 1'b1;
    wait_ack(lat, d);
    check("A_data", d, fdata(22'h000100));
    check("A_fetch", logged(n), 22'h000100);
    check("A_one_fetch", fl_log.size() - n, 1);
    wait_quiet();
    check("A_prefetch", logged(n + 1), 22'h000101);
    check("A_fetch_count", fl_log.size() - n, 2);
    n = fl_log.size();
    do_req(22'h000101, 1'b0, lat, d);
    check("B_lat", lat, 1);
    check("B_data", d, fdata(22'h000101));
    tick(2);
    check("B_no_fetch", fl_log.size() - n, 0);
    // unrelated demand arriving during a prefetch
    wait_quiet();
    n = fl_log.size();
    do_req(22'h000300, 1'b0, lat, d);
    check("C_first_data", d, fdata(22'h000300));
    wait_busy();
    ac = ack_count;
    do_req(22'h000200, 1'b0, lat, d);
    check("C_data", d, fdata(22'h000200));
    check("C_pf_first", logged(n + 1), 22'h000301);
    check("C_then_demand", logged(n + 2), 22'h000200);
    wait_quiet();
    check("C_one_ack", ack_count - ac, 1);
    // demand for the very word being prefetched
    n = fl_log.size();
    do_req(22'h000400, 1'b0, lat, d);
    wait_busy();
    do_req(22'h000401, 1'b0, lat, d);
    check("D_data", d, fdata(22'h000401));
    check("D_ack_after_fall", cyc - fall_cyc, 1);
    check("D_single_fetch", fl_log.size() - n, 2);
    check("D_fetch_addr", logged(n + 1), 22'h000401);
    for (int i = 0; i < 12; i++) begin
      wait_quiet();
      n = fl_log.size();
      do_req(tbl[i].addr, tbl[i].flush, lat, d);
      check($sformatf("tbl%0d_data", i), d, fdata(tbl[i].addr));
      check($sformatf("tbl%0d_hit", i), lat == 1, tbl[i].hit);
      check($sformatf("tbl%0d_fetch", i), logged(n) == longint'(tbl[i].addr), !tbl[i].hit);
    end
    wait_quiet();
    ac = ack_count; nreq = 0; prev = 22'h000020;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      a = (r < 40) ? prev + 22'd1 : (r < 60) ? prev : 22'($urandom_range(0, 63));
      fl = ($urandom_range(0, 99) < 5);
      tick($urandom_range(0, 4));
      quiet = !fl_act && !fl_done && !flash_cs;
      ph = !fl && mv[a[3:0]] && (mt[a[3:0]] == a[21:4]);
      do_req(a, fl, lat, d);
      nreq++;
      check("rnd_data", d, fdata(a));
      if (quiet) check("rnd_hit", lat == 1, ph);
      prev = a;
    end
    wait_quiet();
    check("rnd_acks", ack_count - ac, nreq);
    // reset while a fetch sits in WAIT_DONE
    do_req(22'h000050, 1'b0, lat, d);
    wait_quiet();
    bus.req = 1'b1; bus.req_addr = 22'h000065;
    tick();
    bus.req = 1'b0;
    wait_busy();
    tick();
    resetn = 1'b0;
    #1;
    check("G_rst_ack", bus.ack, 0);
    check("G_rst_cs", flash_cs, 0);
    check("G_rst_addr", flash_address, 0);
    check("G_rst_rdata", bus.rdata, 0);
    tick();
    resetn = 1'b1;
    tick(2);
    n = fl_log.size();
    do_req(22'h000050, 1'b0, lat, d);
    check("G_miss_after_rst", lat > 1, 1);
    check("G_refetch", logged(n), 22'h000050);
    check("G_data", d, fdata(22'h000050));
    wait_quiet();
    check("cs_while_busy", viol, 0);
    check("cs_width", bad_width, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
